// File: rtl/rbm_load.sv
// Read-side DMA front end of the RBM accelerator: issues one read request per user row
// and writes the low byte of each returned beat into the visible-unit buffer.
module rbm_load #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              conf_done,
  input  logic [31:0]       conf_num_movies,
  input  logic [31:0]       conf_num_users,
  input  logic              start,
  input  logic [15:0]       user_idx,
  input  logic              rd_grant,
  input  logic              data_valid,
  input  logic [31:0]       data_in,
  output logic              init_done,
  output logic [15:0]       num_movies,
  output logic [15:0]       num_users,
  output logic              rd_request,
  output logic              rd_granted,
  output logic [31:0]       rd_index,
  output logic [31:0]       rd_length,
  output logic              rd_complete,
  output logic              busy,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_data
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
  state_t state, state_nxt;

  // Beat counter carries one extra bit so a full DEPTH-long row can be compared.
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] cnt_inc;
  logic            last_beat;
  logic            zero_len;
  logic [31:0]     len_clamp;
  logic            unused_bits;

  assign cnt_inc   = cnt + 1'b1;
  assign last_beat = (cnt_inc == rd_length[ADDR_W:0]);
  assign zero_len  = (rd_length == 32'd0);
  assign len_clamp = ({16'd0, num_movies} > 32'(DEPTH)) ? 32'(DEPTH) : {16'd0, num_movies};
  assign busy      = (state != IDLE);
  assign unused_bits = ^{conf_num_movies[31:16], conf_num_users[31:16], data_in[31:DATA_W]};

  // Handshake: rd_request stays high from start until the first step cycle with rd_grant;
  // afterwards every step cycle with data_valid in XFER is one accepted beat (no back-pressure).
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (step && !conf_done && start && init_done) state_nxt = REQ;
      REQ:  if (step && rd_grant) state_nxt = zero_len ? IDLE : XFER;
      XFER: if (step && data_valid && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_done   <= 1'b0;
      num_movies  <= '0;
      num_users   <= '0;
      rd_request  <= 1'b0;
      rd_granted  <= 1'b0;
      rd_index    <= '0;
      rd_length   <= '0;
      rd_complete <= 1'b0;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
      cnt         <= '0;
    end else begin
      buf_we      <= 1'b0;
      rd_complete <= 1'b0;
      if (step) begin
        case (state)
          IDLE: begin
            // Configuration has priority: a coincident start is dropped.
            if (conf_done) begin
              num_movies <= conf_num_movies[15:0];
              num_users  <= conf_num_users[15:0];
              init_done  <= 1'b1;
            end else if (start && init_done) begin
              rd_index   <= {16'd0, user_idx} * {16'd0, num_movies};
              rd_length  <= len_clamp;
              rd_request <= 1'b1;
              cnt        <= '0;
            end
          end
          REQ: begin
            if (rd_grant) begin
              rd_request <= 1'b0;
              if (zero_len) rd_complete <= 1'b1;
              else          rd_granted  <= 1'b1;
            end
          end
          XFER: begin
            if (data_valid) begin
              buf_we   <= 1'b1;
              buf_addr <= cnt[ADDR_W-1:0];
              buf_data <= data_in[DATA_W-1:0];
              cnt      <= cnt_inc;
              if (last_beat) begin
                rd_granted  <= 1'b0;
                rd_complete <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
